// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl
//
// Stall / flush controller for a five-stage in-order pipeline
// (F -> D -> E -> M -> W). It decides, every cycle, which pipeline registers
// advance (en_*), which are loaded with a bubble (clr_*), when the multi-cycle
// divider is launched (div_go) and counts cycles in which the PC is frozen.
//
// Event priority, highest first:
//   exception in M > data-memory stall > divide > load-use hazard > branch
//
// Ports
//   clk            in   clock; all state updates on the rising edge
//   rst_n          in   asynchronous active-low reset
//   exc_m          in   exception in M stage
//   dmem_req       in   M-stage data memory access active
//   dmem_ack       in   data memory completes this cycle
//   div_start_e    in   divide instruction in E, first cycle
//   div_ready      in   divider result valid (one-cycle pulse)
//   lu_hz_d        in   load-use hazard detected in D
//   br_taken_d     in   branch/jump resolved taken in D
//   en_pc/fd/de/em/mw   out  PC and pipeline-register enables
//   clr_fd/de/em/mw     out  synchronous bubble-insert clears
//   div_go         out  one-cycle divider launch pulse
//   stall_cnt      out  saturating count of cycles with en_pc=0
//   dbg_state_o    out  current FSM state (RUN=0, MEM_WAIT=1, DIV_WAIT=2)
//
// Handshake: a memory access is outstanding while dmem_req=1 and dmem_ack=0;
// the cycle with dmem_ack=1 completes it. div_ready is a single-cycle pulse,
// so a pulse that lands while the pipe is frozen by memory is remembered in
// div_done until the pipe can move again.
// -----------------------------------------------------------------------------
module pipe_ctrl #(
    parameter int p_cntw = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              exc_m,
    input  logic              dmem_req,
    input  logic              dmem_ack,
    input  logic              div_start_e,
    input  logic              div_ready,
    input  logic              lu_hz_d,
    input  logic              br_taken_d,
    output logic              en_pc,
    output logic              en_fd,
    output logic              en_de,
    output logic              en_em,
    output logic              en_mw,
    output logic              clr_fd,
    output logic              clr_de,
    output logic              clr_em,
    output logic              clr_mw,
    output logic              div_go,
    output logic [p_cntw-1:0] stall_cnt,
    output logic [1:0]        dbg_state_o
);

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] ST_DIV_WAIT = 2'd2;

    localparam logic [p_cntw-1:0] CNT_ONE = {{(p_cntw-1){1'b0}}, 1'b1};
    localparam logic [p_cntw-1:0] CNT_MAX = {p_cntw{1'b1}};

    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic              div_done_q;
    logic              div_done_d;
    logic [p_cntw-1:0] stall_cnt_q;
    logic [p_cntw-1:0] stall_cnt_d;
    logic              mem_stall;

    assign mem_stall = dmem_req & ~dmem_ack;

    // Next-state and output decode. Outputs depend on the present state and
    // the current inputs, so the enables take effect in the same cycle the
    // event is seen.
    always_comb begin
        en_pc      = 1'b1;
        en_fd      = 1'b1;
        en_de      = 1'b1;
        en_em      = 1'b1;
        en_mw      = 1'b1;
        clr_fd     = 1'b0;
        clr_de     = 1'b0;
        clr_em     = 1'b0;
        clr_mw     = 1'b0;
        div_go     = 1'b0;
        state_d    = state_q;
        div_done_d = div_done_q;

        if (!rst_n) begin
            // Hold everything and flush every register while in reset.
            en_pc      = 1'b0;
            en_fd      = 1'b0;
            en_de      = 1'b0;
            en_em      = 1'b0;
            en_mw      = 1'b0;
            clr_fd     = 1'b1;
            clr_de     = 1'b1;
            clr_em     = 1'b1;
            clr_mw     = 1'b1;
            state_d    = ST_RUN;
            div_done_d = 1'b0;
        end else if (exc_m) begin
            // Flush everything younger than M; the excepting instruction
            // itself still reaches W. Any divide in flight is dropped.
            clr_fd     = 1'b1;
            clr_de     = 1'b1;
            clr_em     = 1'b1;
            state_d    = ST_RUN;
            div_done_d = 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (mem_stall) begin
                        en_pc   = 1'b0;
                        en_fd   = 1'b0;
                        en_de   = 1'b0;
                        en_em   = 1'b0;
                        en_mw   = 1'b0;
                        state_d = ST_MEM_WAIT;
                    end else if (div_start_e) begin
                        // Launch divider; hold F/D/E and bubble into M
                        // while older instructions drain through M/W.
                        div_go  = 1'b1;
                        en_pc   = 1'b0;
                        en_fd   = 1'b0;
                        en_de   = 1'b0;
                        clr_em  = 1'b1;
                        state_d = ST_DIV_WAIT;
                    end else if (lu_hz_d) begin
                        // Hold F/D, bubble into E. A branch in D is not
                        // acted on: the instruction re-evaluates next cycle.
                        en_pc  = 1'b0;
                        en_fd  = 1'b0;
                        clr_de = 1'b1;
                    end else if (br_taken_d) begin
                        clr_fd = 1'b1;
                    end
                end

                ST_MEM_WAIT: begin
                    if (mem_stall) begin
                        en_pc = 1'b0;
                        en_fd = 1'b0;
                        en_de = 1'b0;
                        en_em = 1'b0;
                        en_mw = 1'b0;
                    end else begin
                        state_d = ST_RUN;
                    end
                end

                ST_DIV_WAIT: begin
                    if (mem_stall) begin
                        en_pc = 1'b0;
                        en_fd = 1'b0;
                        en_de = 1'b0;
                        en_em = 1'b0;
                        en_mw = 1'b0;
                        // Keep a result pulse that arrives while frozen.
                        if (div_ready) begin
                            div_done_d = 1'b1;
                        end
                    end else if (div_ready || div_done_q) begin
                        state_d    = ST_RUN;
                        div_done_d = 1'b0;
                    end else begin
                        en_pc  = 1'b0;
                        en_fd  = 1'b0;
                        en_de  = 1'b0;
                        clr_em = 1'b1;
                    end
                end

                default: begin
                    // Unused encoding: recover to RUN.
                    state_d    = ST_RUN;
                    div_done_d = 1'b0;
                end
            endcase
        end
    end

    // Saturating frozen-PC counter.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!en_pc && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            div_done_q  <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            div_done_q  <= div_done_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt   = stall_cnt_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl
//
// Directed bench for pipe_ctrl. Two instances share one stimulus: the default
// 16-bit counter and a 2-bit counter that exercises saturation. Each step
// drives the inputs on the falling edge, pushes the expected outputs, state
// and counter values, and compares just after the inputs settle.
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;

  localparam int W = 30;

  // {en_pc,en_fd,en_de,en_em,en_mw, clr_fd,clr_de,clr_em,clr_mw, div_go}
  localparam logic [9:0] O_RST = 10'b00000_1111_0;
  localparam logic [9:0] O_DEF = 10'b11111_0000_0;
  localparam logic [9:0] O_STL = 10'b00000_0000_0;
  localparam logic [9:0] O_EXC = 10'b11111_1110_0;
  localparam logic [9:0] O_DGO = 10'b00011_0010_1;
  localparam logic [9:0] O_DWT = 10'b00011_0010_0;
  localparam logic [9:0] O_LU  = 10'b00111_0100_0;
  localparam logic [9:0] O_BR  = 10'b11111_1000_0;

  localparam logic [1:0] S_RUN = 2'd0;
  localparam logic [1:0] S_MEM = 2'd1;
  localparam logic [1:0] S_DIV = 2'd2;

  // {exc_m, dmem_req, dmem_ack, div_start_e, div_ready, lu_hz_d, br_taken_d}
  localparam logic [6:0] I_NONE  = 7'b0000000;
  localparam logic [6:0] I_LUBR  = 7'b0000011;
  localparam logic [6:0] I_BR    = 7'b0000001;
  localparam logic [6:0] I_MS    = 7'b0100000;
  localparam logic [6:0] I_MA    = 7'b0110000;
  localparam logic [6:0] I_DS    = 7'b0001000;
  localparam logic [6:0] I_DR    = 7'b0000100;
  localparam logic [6:0] I_MSDR  = 7'b0100100;
  localparam logic [6:0] I_EXCMS = 7'b1100000;
  localparam logic [6:0] I_EXCDS = 7'b1001000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic exc_m, dmem_req, dmem_ack, div_start_e, div_ready, lu_hz_d, br_taken_d;

  logic a_en_pc, a_en_fd, a_en_de, a_en_em, a_en_mw;
  logic a_clr_fd, a_clr_de, a_clr_em, a_clr_mw, a_div_go;
  logic [15:0] a_cnt;
  logic [1:0]  a_state;

  logic b_en_pc, b_en_fd, b_en_de, b_en_em, b_en_mw;
  logic b_clr_fd, b_clr_de, b_clr_em, b_clr_mw, b_div_go;
  logic [1:0] b_cnt;
  logic [1:0] b_state;

  pipe_ctrl #(.p_cntw(16)) dut (
    .clk(clk), .rst_n(rst_n), .exc_m(exc_m), .dmem_req(dmem_req),
    .dmem_ack(dmem_ack), .div_start_e(div_start_e), .div_ready(div_ready),
    .lu_hz_d(lu_hz_d), .br_taken_d(br_taken_d),
    .en_pc(a_en_pc), .en_fd(a_en_fd), .en_de(a_en_de), .en_em(a_en_em),
    .en_mw(a_en_mw), .clr_fd(a_clr_fd), .clr_de(a_clr_de), .clr_em(a_clr_em),
    .clr_mw(a_clr_mw), .div_go(a_div_go), .stall_cnt(a_cnt),
    .dbg_state_o(a_state)
  );

  pipe_ctrl #(.p_cntw(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .exc_m(exc_m), .dmem_req(dmem_req),
    .dmem_ack(dmem_ack), .div_start_e(div_start_e), .div_ready(div_ready),
    .lu_hz_d(lu_hz_d), .br_taken_d(br_taken_d),
    .en_pc(b_en_pc), .en_fd(b_en_fd), .en_de(b_en_de), .en_em(b_en_em),
    .en_mw(b_en_mw), .clr_fd(b_clr_fd), .clr_de(b_clr_de), .clr_em(b_clr_em),
    .clr_mw(b_clr_mw), .div_go(b_div_go), .stall_cnt(b_cnt),
    .dbg_state_o(b_state)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] m_cnt = '0;
  logic [1:0]  m_cnt2 = '0;

  // ---------------- driver ----------------
  task automatic step(input logic rst, input logic [6:0] ins,
                      input logic [9:0] eo, input logic [1:0] es,
                      input string tag);
    logic [W-1:0] e;
    logic [9:0]   ao;
    @(negedge clk);
    rst_n = rst;
    {exc_m, dmem_req, dmem_ack, div_start_e, div_ready, lu_hz_d, br_taken_d} = ins;
    if (!rst) begin
      m_cnt  = '0;
      m_cnt2 = '0;
    end
    exp_q.push_back({eo, es, m_cnt, m_cnt2});
    #1;
    e  = exp_q.pop_front();
    ao = {a_en_pc, a_en_fd, a_en_de, a_en_em, a_en_mw,
          a_clr_fd, a_clr_de, a_clr_em, a_clr_mw, a_div_go};
    n_cmp++;
    assert (ao === e[29:20]) else begin
      n_err++;
      $error("FAIL %s outputs got %b want %b", tag, ao, e[29:20]);
    end
    n_cmp++;
    assert (a_state === e[19:18]) else begin
      n_err++;
      $error("FAIL %s state got %0d want %0d", tag, a_state, e[19:18]);
    end
    n_cmp++;
    assert (a_cnt === e[17:2]) else begin
      n_err++;
      $error("FAIL %s stall_cnt got %0d want %0d", tag, a_cnt, e[17:2]);
    end
    n_cmp++;
    assert (b_cnt === e[1:0]) else begin
      n_err++;
      $error("FAIL %s stall_cnt_sat got %0d want %0d", tag, b_cnt, e[1:0]);
    end
    // Counter model: one more frozen-PC cycle is recorded at the next edge.
    if (rst && !eo[9]) begin
      if (m_cnt != 16'hffff) m_cnt = m_cnt + 16'd1;
      if (m_cnt2 != 2'd3) m_cnt2 = m_cnt2 + 2'd1;
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b1;
    {exc_m, dmem_req, dmem_ack, div_start_e, div_ready, lu_hz_d, br_taken_d} = I_NONE;

    // reset behaviour, even with a memory stall requested
    step(1'b0, I_MS,   O_RST, S_RUN, "rst_hold");
    step(1'b0, I_NONE, O_RST, S_RUN, "rst_idle");
    step(1'b1, I_NONE, O_DEF, S_RUN, "run_idle");

    // load-use beats branch
    step(1'b1, I_LUBR, O_LU,  S_RUN, "lu_br");
    step(1'b1, I_NONE, O_DEF, S_RUN, "after_lu");
    step(1'b1, I_BR,   O_BR,  S_RUN, "branch");
    step(1'b1, I_DR,   O_DEF, S_RUN, "ready_in_run");

    // three-cycle memory stall then ack
    step(1'b1, I_MS,   O_STL, S_RUN, "mem_1");
    step(1'b1, I_MS,   O_STL, S_MEM, "mem_2");
    step(1'b1, I_MS,   O_STL, S_MEM, "mem_3");
    step(1'b1, I_MA,   O_DEF, S_MEM, "mem_ack");
    step(1'b1, I_NONE, O_DEF, S_RUN, "mem_done");

    // div_ready during MEM_WAIT has no effect
    step(1'b1, I_MS,   O_STL, S_RUN, "memr_1");
    step(1'b1, I_MSDR, O_STL, S_MEM, "memr_rdy");
    step(1'b1, I_MA,   O_DEF, S_MEM, "memr_ack");
    step(1'b1, I_NONE, O_DEF, S_RUN, "memr_done");

    // divide, ready five cycles after launch
    step(1'b1, I_DS,   O_DGO, S_RUN, "div_go");
    for (int i = 0; i < 4; i++) step(1'b1, I_NONE, O_DWT, S_DIV, "div_wait");
    step(1'b1, I_DR,   O_DEF, S_DIV, "div_ready");
    step(1'b1, I_NONE, O_DEF, S_RUN, "div_done");

    // ready lands inside a two-cycle memory stall during DIV_WAIT
    step(1'b1, I_DS,   O_DGO, S_RUN, "dm_go");
    step(1'b1, I_NONE, O_DWT, S_DIV, "dm_wait");
    step(1'b1, I_MSDR, O_STL, S_DIV, "dm_stall_rdy");
    step(1'b1, I_MS,   O_STL, S_DIV, "dm_stall_2");
    step(1'b1, I_MA,   O_DEF, S_DIV, "dm_ack_exit");
    step(1'b1, I_NONE, O_DEF, S_RUN, "dm_run");

    // exception during DIV_WAIT with a memory stall; late ready ignored
    step(1'b1, I_DS,    O_DGO, S_RUN, "de_go");
    step(1'b1, I_NONE,  O_DWT, S_DIV, "de_wait");
    step(1'b1, I_EXCMS, O_EXC, S_DIV, "de_exc");
    step(1'b1, I_DR,    O_DEF, S_RUN, "de_late_rdy");
    step(1'b1, I_NONE,  O_DEF, S_RUN, "de_run");

    // exception outranks divide launch and memory stall in RUN
    step(1'b1, I_EXCDS, O_EXC, S_RUN, "exc_vs_div");
    step(1'b1, I_NONE,  O_DEF, S_RUN, "exc_div_run");
    step(1'b1, I_EXCMS, O_EXC, S_RUN, "exc_vs_mem");
    step(1'b1, I_NONE,  O_DEF, S_RUN, "exc_mem_run");

    // long stall saturates the 2-bit counter, reset pulse mid-stall
    step(1'b1, I_MS, O_STL, S_RUN, "sat_1");
    for (int i = 0; i < 5; i++) step(1'b1, I_MS, O_STL, S_MEM, "sat_n");
    step(1'b0, I_MS,   O_RST, S_RUN, "rst_mid");
    step(1'b1, I_NONE, O_DEF, S_RUN, "post_rst");
    step(1'b1, I_LUBR, O_LU,  S_RUN, "post_rst_lu");
    step(1'b1, I_NONE, O_DEF, S_RUN, "post_rst_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
